// File: rtl/cpu_commit_mem.sv
// Commit/memory stage: forwards ALU results, writes back ALU/load values, and
// runs loads/stores through a valid/ready data-cache port while stalling upstream.
module cpu_commit_mem #(
    parameter  int REG_WIDTH = 32,
    parameter  int NUM_REGS  = 32,
    localparam int RID       = $clog2(NUM_REGS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [REG_WIDTH-1:0] in_alu_result,
    input  logic [REG_WIDTH-1:0] in_rb_data,
    input  logic [RID-1:0]       in_rd_id,
    input  logic                 in_writeback,
    input  logic                 in_mem_read,
    input  logic                 in_mem_write,
    input  logic                 in_mem_byte,
    output logic                 stall_out,
    output logic                 dc_req_valid,
    input  logic                 dc_req_ready,
    output logic                 dc_req_we,
    output logic [REG_WIDTH-1:0] dc_req_addr,
    output logic [REG_WIDTH-1:0] dc_req_wdata,
    output logic [3:0]           dc_req_be,
    input  logic                 dc_resp_valid,
    input  logic [REG_WIDTH-1:0] dc_resp_rdata,
    output logic                 commit_fwd_valid,
    output logic [RID-1:0]       commit_rd_id,
    output logic [REG_WIDTH-1:0] commit_value,
    output logic                 wb_valid,
    output logic [RID-1:0]       wb_rd_id,
    output logic [REG_WIDTH-1:0] wb_data,
    output logic                 exc_misaligned
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t         state;
    logic           memop;
    logic           aligned;
    logic [1:0]     req_off;
    logic           req_byte;
    logic [RID-1:0] req_rd;
    logic [7:0]     load_byte;
    logic [REG_WIDTH-1:0] load_value;

    assign memop   = in_valid & (in_mem_read | in_mem_write);
    assign aligned = in_mem_byte | (in_alu_result[1:0] == 2'b00);

    assign commit_fwd_valid = in_valid & in_writeback & ~in_mem_read & ~in_mem_write;
    assign commit_value     = in_alu_result;
    assign commit_rd_id     = in_rd_id;

    // Stall drops in the response cycle so upstream advances as the access retires.
    assign stall_out = ((state == IDLE) & memop & aligned)
                     | (state == REQ)
                     | ((state == WAIT) & ~dc_resp_valid);

    always_comb begin
        load_byte = dc_resp_rdata[7:0];
        case (req_off)
            2'd1:    load_byte = dc_resp_rdata[15:8];
            2'd2:    load_byte = dc_resp_rdata[23:16];
            2'd3:    load_byte = dc_resp_rdata[31:24];
            default: load_byte = dc_resp_rdata[7:0];
        endcase
    end

    assign load_value = req_byte ? {{(REG_WIDTH-8){1'b0}}, load_byte} : dc_resp_rdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            dc_req_valid   <= 1'b0;
            dc_req_we      <= 1'b0;
            dc_req_addr    <= '0;
            dc_req_wdata   <= '0;
            dc_req_be      <= 4'h0;
            req_off        <= 2'b00;
            req_byte       <= 1'b0;
            req_rd         <= '0;
            wb_valid       <= 1'b0;
            wb_rd_id       <= '0;
            wb_data        <= '0;
            exc_misaligned <= 1'b0;
        end else begin
            wb_valid       <= 1'b0;
            exc_misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (memop) begin
                        if (aligned) begin
                            // A load+store combination is handled as a load.
                            dc_req_valid <= 1'b1;
                            dc_req_we    <= ~in_mem_read;
                            dc_req_addr  <= {in_alu_result[REG_WIDTH-1:2], 2'b00};
                            dc_req_wdata <= in_mem_byte ? {4{in_rb_data[7:0]}} : in_rb_data;
                            dc_req_be    <= in_mem_byte ? (4'b0001 << in_alu_result[1:0]) : 4'hF;
                            req_off      <= in_alu_result[1:0];
                            req_byte     <= in_mem_byte;
                            req_rd       <= in_rd_id;
                            state        <= REQ;
                        end else begin
                            exc_misaligned <= 1'b1;
                        end
                    end else if (in_valid) begin
                        wb_valid <= in_writeback;
                        wb_rd_id <= in_rd_id;
                        wb_data  <= in_alu_result;
                    end
                end
                REQ: begin
                    if (dc_req_ready) begin
                        dc_req_valid <= 1'b0;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (dc_resp_valid) begin
                        state <= IDLE;
                        if (!dc_req_we) begin
                            wb_valid <= 1'b1;
                            wb_rd_id <= req_rd;
                            wb_data  <= load_value;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cpu_commit_mem.md
Name: cpu_commit_mem

Overview:
- Commit/memory stage directly downstream of the execute stage.
- Consumes execute results: ALU result/address, store data, destination register, control bits.
- Performs loads/stores through a valid/ready data-cache port and stalls upstream while an access is outstanding.
- Drives the commit forwarding value and the registered ALU/load write-back port of the register bank.

Parameters:
- REG_WIDTH, 32, datapath width; only 32 supported (byte lanes fixed at 4).
- NUM_REGS, 32, architectural registers; RID = clog2(NUM_REGS).

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  instruction present from execute
- in_alu_result  in  REG_WIDTH  ALU result / memory address
- in_rb_data  in  REG_WIDTH  store data
- in_rd_id  in  RID  destination register
- in_writeback  in  1  instruction writes rd
- in_mem_read  in  1  load
- in_mem_write  in  1  store
- in_mem_byte  in  1  byte access (else word)
- stall_out  out  1  freeze execute and earlier stages
- dc_req_valid  out  1  cache request valid
- dc_req_ready  in  1  cache accepts request
- dc_req_we  out  1  1 = store
- dc_req_addr  out  REG_WIDTH  word-aligned address (addr[1:0]=0)
- dc_req_wdata  out  REG_WIDTH  store data
- dc_req_be  out  4  byte enables
- dc_resp_valid  in  1  response (load data or store ack)
- dc_resp_rdata  in  REG_WIDTH  load word
- commit_fwd_valid  out  1  forwarding value valid
- commit_rd_id  out  RID  forwarding destination
- commit_value  out  REG_WIDTH  forwarding value
- wb_valid  out  1  register-bank write enable
- wb_rd_id  out  RID  write destination
- wb_data  out  REG_WIDTH  write data
- exc_misaligned  out  1  one-cycle misaligned-word pulse

Behaviour:
- Reset: state IDLE; dc_req_valid, wb_valid, exc_misaligned = 0; wb_rd_id, wb_data, request registers = 0. Reset mid-access abandons it. A dc_resp_valid arriving in IDLE is ignored.
- memop = in_valid & (in_mem_read | in_mem_write). Both set: treated as a load.
- Aligned: byte access, or addr[1:0] == 0.
- Forwarding (combinational):
  - commit_fwd_valid = in_valid & in_writeback & ~in_mem_read & ~in_mem_write.
  - commit_value = in_alu_result; commit_rd_id = in_rd_id.
- Non-memory op: at the next edge, wb_valid = in_writeback, wb_rd_id = in_rd_id, wb_data = in_alu_result. Latency 1; no stall.
- Otherwise wb_valid is 0 each cycle unless a load completes.
- Misaligned word memop: no request, no write-back, no stall; exc_misaligned = 1 for one cycle after the edge.
- FSM:
  - IDLE: aligned memop → capture addr/data/byte/we/rd, go REQ.
  - REQ: dc_req_valid = 1 from registers, held stable until dc_req_ready; on handshake → WAIT.
  - WAIT: on dc_resp_valid → IDLE.
    - Load: at that edge wb_valid = 1, wb_rd_id = captured rd, wb_data = loaded value.
    - Store: no write-back.
- stall_out = (IDLE & aligned memop) | REQ | (WAIT & ~dc_resp_valid). It drops in the response cycle so upstream advances at the same edge the access retires. Inputs are held stable by upstream while stall_out = 1.
- Byte store: dc_req_be = 1 << addr[1:0]; wdata = rb_data[7:0] replicated in all four lanes.
- Word store: dc_req_be = 4'hF.
- Byte load: zero-extended dc_resp_rdata byte selected by captured addr[1:0].
- Word load: full word.
- dc_req_addr = {addr[31:2], 2'b00}.
- Minimum load timing (ready and response immediate):
  - accept cycle N; REQ N+1; WAIT/resp N+2; wb_valid N+3.
  - stall_out high N and N+1.

Test Plan:
- ADD result 0x0000_0010, rd=5, writeback=1 → next cycle wb_valid=1, wb_rd_id=5, wb_data=0x10; commit_fwd_valid=1 in the input cycle; stall_out never set.
- Word load addr 0x100, ready=1, rdata 0xDEADBEEF after one WAIT cycle, rd=7 → dc_req_addr=0x100, be=4'hF; stall_out high 2 cycles; wb 7 ← 0xDEADBEEF at N+3.
- Byte load addr 0x203, rdata 0x11223344 → wb_data=0x00000011.
- Byte store addr 0x301, rb=0xAABBCCDD, ready held low 3 cycles → dc_req_valid and fields stable all 4 cycles; be=4'b0010, wdata=0xDDDDDDDD; no wb; stall released on ack.
- Word load addr 0x102 → exc_misaligned pulse, dc_req_valid=0, wb_valid=0, stall_out=0.
- Reset asserted in WAIT → IDLE, stall_out=0; late dc_resp_valid produces no wb_valid.
